// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: round-robin shared double-dabble binary-to-BCD converter with per-requester result bank
module bcd_conv_sched #(
   parameter int NUM_REQ   = 3,
   parameter int BIN_WIDTH = 16,
   parameter int BCD_WIDTH = 5,
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [NUM_REQ-1:0]             req_i,
   input  logic [NUM_REQ*BIN_WIDTH-1:0]   bin_i,
   output logic [NUM_REQ-1:0]             ack_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [PW-1:0]                  done_id_o,
   output logic [NUM_REQ*BCD_WIDTH*4-1:0] bcd_o,
   output logic [NUM_REQ-1:0]             ovf_o
);
   localparam int CW = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
   localparam int DW = BCD_WIDTH * 4;

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t                   state_q, state_d;
   logic [PW-1:0]            ptr_q, ptr_d, gid_q, gid_d, gnt;
   logic [BIN_WIDTH-1:0]     opnd_q, opnd_d;
   logic [DW-1:0]            dig_q, dig_d, adj;
   logic                     flag_q, flag_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [NUM_REQ*DW-1:0]    bank_q, bank_d;
   logic [NUM_REQ-1:0]       ovfb_q, ovfb_d;

   assign bcd_o = bank_q;
   assign ovf_o = ovfb_q;

   // Round-robin pick: lowest requester at or above the pointer, else lowest overall (wrap)
   always_comb begin
      gnt = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) if (req_i[i]) gnt = PW'(i);
      for (int i = NUM_REQ - 1; i >= 0; i--) if (req_i[i] && PW'(i) >= ptr_q) gnt = PW'(i);
   end

   // Digit correction: every digit >= 5 gets +3 before the shift
   always_comb begin
      adj = dig_q;
      for (int d = 0; d < BCD_WIDTH; d++) adj[d*4 +: 4] = (dig_q[d*4 +: 4] >= 4'd5) ? dig_q[d*4 +: 4] + 4'd3 : dig_q[d*4 +: 4];
   end

   // Next-state and output logic; ack is masked while reset is asserted so outputs read 0
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gid_d     = gid_q;
      opnd_d    = opnd_q;
      dig_d     = dig_q;
      flag_d    = flag_q;
      cnt_d     = cnt_q;
      bank_d    = bank_q;
      ovfb_d    = ovfb_q;
      ack_o     = '0;
      done_o    = 1'b0;
      done_id_o = '0;
      busy_o    = state_q != IDLE;
      unique case (state_q)
         IDLE: if (|req_i && !rst_i) begin
            ack_o   = NUM_REQ'(1) << gnt;
            gid_d   = gnt;
            for (int i = 0; i < NUM_REQ; i++) if (gnt == PW'(i)) opnd_d = bin_i[i*BIN_WIDTH +: BIN_WIDTH];
            dig_d   = '0;
            flag_d  = 1'b0;
            cnt_d   = CW'(BIN_WIDTH - 1);
            state_d = CONV;
         end
         CONV: begin
            dig_d   = {adj[DW-2:0], opnd_q[BIN_WIDTH-1]};
            flag_d  = flag_q | adj[DW-1];
            opnd_d  = opnd_q << 1;
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == '0) ? DONE : CONV;
         end
         DONE: begin
            for (int i = 0; i < NUM_REQ; i++) if (gid_q == PW'(i)) begin
               bank_d[i*DW +: DW] = flag_q ? {BCD_WIDTH{4'h9}} : dig_q;
               ovfb_d[i]          = flag_q;
            end
            done_o    = 1'b1;
            done_id_o = gid_q;
            ptr_d     = (gid_q == PW'(NUM_REQ - 1)) ? '0 : gid_q + PW'(1);
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any conversion and clears the result bank
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         opnd_q  <= '0;
         dig_q   <= '0;
         flag_q  <= 1'b0;
         cnt_q   <= '0;
         bank_q  <= '0;
         ovfb_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         opnd_q  <= opnd_d;
         dig_q   <= dig_d;
         flag_q  <= flag_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
         ovfb_q  <= ovfb_d;
      end
   end
endmodule
